// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared add/sub/and/xor ALU with a one-entry result register.
// Contention policy: ALU_ARB_RR_EN defined selects round-robin, otherwise requester 0 has fixed priority.
module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_fn,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_fn,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_val,
   output logic [2:0]       rsp_cc
);

   localparam logic [1:0] FN_ADD = 2'd0;
   localparam logic [1:0] FN_SUB = 2'd1;
   localparam logic [1:0] FN_AND = 2'd2;
   localparam logic [1:0] FN_XOR = 2'd3;

`ifdef ALU_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic             r_valid;
   logic             r_id;
   logic [WIDTH-1:0] r_val;
   logic [2:0]       r_cc;
   logic             r_last_grant;

   logic             w_slot_free;
   logic             w_gnt1;
   logic             w_accept;
   logic [1:0]       w_fn;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic             w_sub;
   logic [WIDTH-1:0] w_b_eff;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_res;
   logic             w_zf;
   logic             w_sf;
   logic             w_of;

   // Requester 1 wins when alone, or on contention when round-robin says it is its turn.
   assign w_slot_free = !r_valid || rsp_ready;
   assign w_gnt1      = req1_valid && (!req0_valid || (RR_EN && !r_last_grant));
   assign w_accept    = !rst && w_slot_free && (req0_valid || req1_valid);
   assign req0_ready  = w_accept && !w_gnt1;
   assign req1_ready  = w_accept && w_gnt1;

   assign w_fn = w_gnt1 ? req1_fn : req0_fn;
   assign w_a  = w_gnt1 ? req1_a  : req0_a;
   assign w_b  = w_gnt1 ? req1_b  : req0_b;

   // One adder serves both add and sub: A + ~B + 1 for subtraction.
   assign w_sub   = (w_fn == FN_SUB);
   assign w_b_eff = w_sub ? ~w_b : w_b;
   assign w_sum   = w_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_sub};

   always_comb begin
      w_res = w_sum;
      case (w_fn)
         FN_AND:  w_res = w_a & w_b;
         FN_XOR:  w_res = w_a ^ w_b;
         default: w_res = w_sum;
      endcase
   end

   assign w_zf = (w_res == '0);
   assign w_sf = w_res[WIDTH-1];
   assign w_of = (w_fn == FN_ADD || w_fn == FN_SUB)
               && (w_a[WIDTH-1] == w_b_eff[WIDTH-1])
               && (w_sum[WIDTH-1] != w_a[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid      <= 1'b0;
         r_id         <= 1'b0;
         r_val        <= '0;
         r_cc         <= 3'b000;
         r_last_grant <= 1'b1;
      end else if (w_accept) begin
         r_valid      <= 1'b1;
         r_id         <= w_gnt1;
         r_val        <= w_res;
         r_cc         <= {w_zf, w_sf, w_of};
         r_last_grant <= w_gnt1;
      end else if (rsp_ready) begin
         r_valid      <= 1'b0;
      end
   end

   assign rsp_valid = r_valid;
   assign rsp_id    = r_id;
   assign rsp_val   = r_val;
   assign rsp_cc    = r_cc;

endmodule
